// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int N_BITS     = 8,
    parameter int SB_TICK    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int NB_PTR     = 2
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              s_tick,
    input  logic              rx,
    input  logic              pop_i,
    input  logic              clear_err_i,
    output logic [N_BITS-1:0] dout,
    output logic              empty_o,
    output logic              full_o,
    output logic              rx_done_tick,
    output logic              frame_err_o,
    output logic              overrun_o
);
    localparam int NB_N = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START     = 5'b00010,
        DATA      = 5'b00100,
        STOP      = 5'b01000,
        WAIT_IDLE = 5'b10000
    } state_t;

    state_t            state_q, state_d;
    logic              rx_meta_q, rx_s_q;
    logic [3:0]        s_q, s_d;
    logic [NB_N-1:0]   n_q, n_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic [N_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [N_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [NB_PTR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NB_PTR:0]   cnt_q, cnt_d;
    logic              rx_done_q, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic              stop_ok, set_fe, set_ov, push, pop, full;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        stop_ok = 1'b0;
        set_fe  = 1'b0;
        case (state_q)
            IDLE: if (!rx_s_q) begin
                s_d     = '0;
                state_d = START;
            end
            START: if (s_tick) begin
                if (s_q == 4'd7) begin
                    // A line that is high again at mid start bit was only a glitch
                    if (rx_s_q) state_d = IDLE;
                    else begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end
                end else s_d = s_q + 4'd1;
            end
            DATA: if (s_tick) begin
                if (s_q == 4'd15) begin
                    s_d = '0;
                    b_d = {rx_s_q, b_q[N_BITS-1:1]};
                    if (n_q == NB_N'(N_BITS - 1)) state_d = STOP;
                    else n_d = n_q + 1'b1;
                end else s_d = s_q + 4'd1;
            end
            STOP: if (s_tick) begin
                if (s_q == 4'(SB_TICK - 1)) begin
                    s_d     = '0;
                    stop_ok = rx_s_q;
                    set_fe  = !rx_s_q;
                    state_d = rx_s_q ? IDLE : WAIT_IDLE;
                end else s_d = s_q + 4'd1;
            end
            WAIT_IDLE: if (rx_s_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A pop on the decision cycle frees the head slot, so a full FIFO still accepts the byte
    always_comb begin
        full        = cnt_q == (NB_PTR + 1)'(FIFO_DEPTH);
        pop         = pop_i && (cnt_q != '0);
        push        = stop_ok && (!full || pop);
        set_ov      = stop_ok && full && !pop;
        mem_d       = mem_q;
        if (push) mem_d[wr_ptr_q] = b_q;
        wr_ptr_d    = wr_ptr_q + NB_PTR'(push);
        rd_ptr_d    = rd_ptr_q + NB_PTR'(pop);
        cnt_d       = cnt_q + (NB_PTR + 1)'(push) - (NB_PTR + 1)'(pop);
        frame_err_d = set_fe || (frame_err_q && !clear_err_i);
        overrun_d   = set_ov || (overrun_q && !clear_err_i);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rx_done_q   <= push;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dout         = mem_q[rd_ptr_q];
    assign empty_o      = cnt_q == '0;
    assign full_o       = full;
    assign rx_done_tick = rx_done_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed UART frames with a scoreboard checking every byte popped from the FIFO
module tb_uart_rx_fifo;
    logic       clock_i = 1'b0, reset_i = 1'b0, s_tick = 1'b0, rx = 1'b1, pop_i = 1'b0, clear_err_i = 1'b0;
    logic [7:0] dout;
    logic       empty_o, full_o, rx_done_tick, frame_err_o, overrun_o;
    int         total = 0, bad = 0, done_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.N_BITS(8), .SB_TICK(16), .FIFO_DEPTH(4), .NB_PTR(2)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .s_tick(s_tick), .rx(rx), .pop_i(pop_i),
        .clear_err_i(clear_err_i), .dout(dout), .empty_o(empty_o), .full_o(full_o),
        .rx_done_tick(rx_done_tick), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
    );

    always #5 clock_i = ~clock_i;

    // 16x tick: one cycle high every four clocks, changing just after the rising edge
    initial forever begin
        repeat (3) @(posedge clock_i);
        #2 s_tick = 1'b1;
        @(posedge clock_i);
        #2 s_tick = 1'b0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    // Monitor: the head byte seen while pop_i is high is the byte leaving the FIFO
    always @(negedge clock_i) begin
        logic [7:0] e;
        if (rx_done_tick) done_cnt++;
        if (reset_i && pop_i && !empty_o) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_pop: got dout=%h, required no byte in FIFO", dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    bad++;
                    $display("FAIL sb_pop: got dout=%h, required %h", dout, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic wait_tick();
        do @(negedge clock_i); while (!s_tick);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) wait_tick();
    endtask

    task automatic drive(input logic v, input int n);
        @(posedge clock_i);
        #2 rx = v;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stop_low, input bit pop_at_stop);
        wait_tick();
        drive(1'b0, 16);
        for (int i = 0; i < 8; i++) drive(d[i], 16);
        if (stop_low > 0) drive(1'b0, stop_low);
        if (pop_at_stop) begin
            // The receiver decides on the 8th tick of the stop bit; pop exactly then
            drive(1'b1, 7);
            repeat (4) @(posedge clock_i);
            #2 pop_i = 1'b1;
            @(posedge clock_i);
            #2 pop_i = 1'b0;
            wait_ticks(8);
        end else drive(1'b1, 16);
    endtask

    task automatic pop_one();
        @(posedge clock_i);
        #2 pop_i = 1'b1;
        @(posedge clock_i);
        #2 pop_i = 1'b0;
        @(negedge clock_i);
    endtask

    task automatic clear_err();
        @(posedge clock_i);
        #2 clear_err_i = 1'b1;
        @(posedge clock_i);
        #2 clear_err_i = 1'b0;
        @(negedge clock_i);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_empty"}, 32'(empty_o), 1);
        chk({tag, "_full"}, 32'(full_o), 0);
        chk({tag, "_done"}, 32'(rx_done_tick), 0);
        chk({tag, "_fe"}, 32'(frame_err_o), 0);
        chk({tag, "_ov"}, 32'(overrun_o), 0);
    endtask

    initial begin
        int d0;
        repeat (5) @(posedge clock_i);
        #2 reset_i = 1'b1;
        @(negedge clock_i);
        chk_reset_state("reset");

        d0 = done_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0, 1'b0);
        chk("single_done", 32'(done_cnt - d0), 1);
        chk("single_dout", 32'(dout), 32'hA5);
        chk("single_empty", 32'(empty_o), 0);
        pop_one();
        chk("single_empty_after_pop", 32'(empty_o), 1);

        d0 = done_cnt;
        wait_tick();
        drive(1'b0, 4);
        drive(1'b1, 16);
        chk("glitch_done", 32'(done_cnt - d0), 0);
        chk("glitch_empty", 32'(empty_o), 1);
        chk("glitch_fe", 32'(frame_err_o), 0);
        chk("glitch_ov", 32'(overrun_o), 0);

        d0 = done_cnt;
        send_frame(8'h3C, 40, 1'b0);
        chk("frame_fe", 32'(frame_err_o), 1);
        chk("frame_empty", 32'(empty_o), 1);
        chk("frame_done", 32'(done_cnt - d0), 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 0, 1'b0);
        chk("frame_next_done", 32'(done_cnt - d0), 1);
        chk("frame_next_dout", 32'(dout), 32'h5A);
        chk("frame_fe_sticky", 32'(frame_err_o), 1);
        clear_err();
        chk("frame_fe_cleared", 32'(frame_err_o), 0);
        pop_one();

        d0 = done_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 0, 1'b0);
            if (i == 4) begin
                chk("ovr_full4", 32'(full_o), 1);
                chk("ovr_ov4", 32'(overrun_o), 0);
            end
        end
        chk("ovr_ov5", 32'(overrun_o), 1);
        chk("ovr_done", 32'(done_cnt - d0), 4);
        repeat (4) pop_one();
        chk("ovr_empty", 32'(empty_o), 1);
        clear_err();
        chk("ovr_cleared", 32'(overrun_o), 0);

        for (int i = 8'h11; i <= 8'h14; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 0, 1'b0);
        end
        chk("coinc_full_before", 32'(full_o), 1);
        d0 = done_cnt;
        exp_q.push_back(8'h15);
        send_frame(8'h15, 0, 1'b1);
        chk("coinc_ov", 32'(overrun_o), 0);
        chk("coinc_full", 32'(full_o), 1);
        chk("coinc_done", 32'(done_cnt - d0), 1);
        repeat (4) pop_one();
        chk("coinc_empty", 32'(empty_o), 1);

        send_frame(8'h66, 0, 1'b0);
        chk("rst_pre_dout", 32'(dout), 32'h66);
        wait_tick();
        drive(1'b0, 16);
        drive(1'b1, 40);
        @(posedge clock_i);
        #2 reset_i = 1'b0;
        repeat (2) @(posedge clock_i);
        #2 reset_i = 1'b1;
        @(negedge clock_i);
        chk_reset_state("midrst");
        wait_ticks(32);
        d0 = done_cnt;
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 0, 1'b0);
        chk("post_rst_done", 32'(done_cnt - d0), 1);
        chk("post_rst_dout", 32'(dout), 32'h7E);
        pop_one();
        chk("post_rst_empty", 32'(empty_o), 1);

        chk("sb_leftover", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Upstream UART receive stage of the debug path.
- Oversamples the serial line at 16 ticks per bit, using the `s_tick` strobe from the baud-rate generator.
- Validates start and stop bits, assembles LSB-first bytes and queues them in a small first-word-fall-through FIFO.
- The debug unit consumes command and instruction bytes from the FIFO; overrun and framing errors are reported as sticky flags.

## Interface
- `N_BITS`, 8: data bits per frame.
- `SB_TICK`, 16: `s_tick` count sampled for the stop bit.
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of two.
- `NB_PTR`, 2: log2(`FIFO_DEPTH`).
- `clock_i`  in  1  single system clock, rising edge.
- `reset_i`  in  1  synchronous, active-low reset.
- `s_tick`  in  1  one-cycle strobe at 16x baud.
- `rx`  in  1  asynchronous serial line, idle high.
- `pop_i`  in  1  consumer removes the head byte.
- `clear_err_i`  in  1  clears both sticky error flags.
- `dout`  out  `N_BITS`  head byte of the FIFO; valid when `empty_o`=0.
- `empty_o`  out  1  FIFO empty.
- `full_o`  out  1  FIFO full.
- `rx_done_tick`  out  1  one-cycle pulse per byte accepted into the FIFO.
- `frame_err_o`  out  1  sticky: stop bit sampled low.
- `overrun_o`  out  1  sticky: a byte was dropped because the FIFO was full.

## Operation
- `rx` passes through a 2-flop synchronizer, giving `rx_s`; the synchronizer resets to 1.
- FSM state register is one-hot; the states are IDLE, START, DATA, STOP and WAIT_IDLE.
- Counters: tick counter `s` (4 bits), bit counter `n` (3 bits) and shift register `b` (`N_BITS` bits).
- `s` and `n` advance only on cycles where `s_tick`=1.
- IDLE:
  - When `rx_s`=0, clear `s` and go to START.
  - No tick is required to leave IDLE.
- START:
  - At `s`==7 (mid start bit): if `rx_s`=0, clear `s` and `n` and go to DATA.
  - If `rx_s`=1 at that point, treat it as a glitch and return to IDLE silently.
  - Otherwise increment `s`.
- DATA:
  - At `s`==15: load `b` = {`rx_s`, `b`[N_BITS-1:1]} and clear `s`.
  - If `n`==N_BITS-1, go to STOP; otherwise increment `n`.
- STOP:
  - Action happens at `s`==SB_TICK-1.
  - `rx_s`=1 and FIFO not full: push `b` and go to IDLE.
  - `rx_s`=1 and FIFO full: drop the byte, set `overrun_o` and go to IDLE.
  - `rx_s`=0: discard the byte, set `frame_err_o` and go to WAIT_IDLE.
- WAIT_IDLE: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- FIFO:
  - Circular buffer with `NB_PTR`-bit read/write pointers plus an occupancy counter of `NB_PTR`+1 bits.
  - Pointers wrap from `FIFO_DEPTH`-1 to 0.
  - `dout` = mem[rd_ptr], first-word-fall-through.
- `pop_i` while `empty_o`=1 is ignored: no pointer movement and no error.
- Simultaneous push and pop:
  - Both take effect and the count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and `overrun_o` is not set.
- `clear_err_i` clears both sticky flags. If it coincides with a new error event, the set wins.

## Timing
- Reset values:
  - State IDLE; `s`, `n`, `b` and both pointers 0.
  - `dout`=0, `empty_o`=1, `full_o`=0, `rx_done_tick`=0, `frame_err_o`=0, `overrun_o`=0.
- The start edge is detected 2 clocks after `rx` falls, because of the synchronizer.
- Push is registered on the STOP decision cycle. On the next clock edge:
  - `rx_done_tick`=1 for exactly one cycle;
  - `empty_o`/`full_o` are updated;
  - the new head is visible on `dout` if the FIFO was empty.
- Pop is registered on a `pop_i` cycle; `dout`, `empty_o` and `full_o` reflect it on the next cycle.
- End-to-end latency from the start-bit falling edge to `rx_done_tick` is about (8 + 16·N_BITS + SB_TICK)·16x-tick periods + 3 clocks.
- Reset mid-frame: the partial byte is discarded, FIFO contents are lost and all outputs return to their reset values on the next edge.

## Test plan
- Single byte: send 0xA5 at 16 ticks/bit. Expect one `rx_done_tick` pulse, `dout`=0xA5, `empty_o`=0. After `pop_i`, expect `empty_o`=1.
- Glitch: hold `rx` low for 4 ticks, then high. Expect FSM back in IDLE, no `rx_done_tick`, FIFO empty, flags 0.
- Framing:
  - Send 0x3C with the stop bit low for 40 ticks, then high. Expect `frame_err_o`=1, FIFO empty, no byte while low.
  - A following 0x5A is received normally.
  - `clear_err_i` then drives `frame_err_o` to 0.
- Overrun: send 0x01..0x05 with no pops. Expect `full_o`=1 after the fourth byte, `overrun_o`=1 after the fifth, and pops returning 0x01, 0x02, 0x03, 0x04, then `empty_o`=1.
- Full plus coincident pop: with the FIFO full of 0x11..0x14, assert `pop_i` on the STOP push cycle of 0x15. Expect `overrun_o`=0, `full_o`=1, and drain order 0x12, 0x13, 0x14, 0x15.
- Reset mid-frame: drop `reset_i` during DATA of 0xFF, then release. Expect all reset values. A subsequent 0x7E is received correctly.
